// File: rtl/qbert_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qbert_pkg
// Description : Shared types and constants for the Q*bert jump animator.
//               Contents:
//                 - direction and FSM state encodings
//                 - position_qb field layout
//                 - pyramid size
//                 - neighbour-cube helper function
// Revision    : 1.0 - initial release
// ============================================================================
package qbert_pkg;

    localparam int N_ROWS = 7;

    // position_qb layout: {x, y, row, col, on_pyr}
    localparam int POS_W      = 28;
    localparam int X_W        = 11;
    localparam int Y_W        = 10;
    localparam int ROW_W      = 3;
    localparam int COL_W      = 3;
    localparam int X_LSB      = 17;
    localparam int Y_LSB      = 7;
    localparam int ROW_LSB    = 4;
    localparam int COL_LSB    = 1;
    localparam int ON_PYR_BIT = 0;

    typedef enum logic [1:0] {
        UP_RIGHT   = 2'b00,
        UP_LEFT    = 2'b01,
        DOWN_RIGHT = 2'b10,
        DOWN_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        JUMP = 2'd1,
        FALL = 2'd2,
        DEAD = 2'd3
    } jump_state_t;

    typedef struct packed {
        logic             valid;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } cube_t;

    // Neighbour cube in the given direction. row/col of an invalid target
    // are don't-care; callers must honour the valid flag.
    function automatic cube_t next_cube(input logic [ROW_W-1:0] row,
                                        input logic [COL_W-1:0] col,
                                        input dir_t             dir);
        cube_t t;
        t.valid = 1'b0;
        t.row   = row;
        t.col   = col;
        case (dir)
            UP_RIGHT: begin
                t.valid = (row != 3'd0) && (col != row);
                t.row   = row - 3'd1;
            end
            UP_LEFT: begin
                t.valid = (row != 3'd0) && (col != 3'd0);
                t.row   = row - 3'd1;
                t.col   = col - 3'd1;
            end
            DOWN_RIGHT: begin
                t.valid = (row < 3'(N_ROWS - 1));
                t.row   = row + 3'd1;
                t.col   = col + 3'd1;
            end
            default: begin
                t.valid = (row < 3'(N_ROWS - 1));
                t.row   = row + 3'd1;
            end
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qbert_cube2xy.sv
`default_nettype none
// ============================================================================
// Module      : qbert_cube2xy
// Description : Combinational cube (row, col) -> screen pixel (x, y).
//               x = ox + CUBE_DX*(2*col - row), y = oy + CUBE_DY*row,
//               wrapping modulo the output widths.
// Ports       : i_row, i_col   cube coordinates
//               i_xy_offset    {ox[10:0], oy[9:0]} pixel position of cube (0,0)
//               o_x, o_y       pixel position of the cube
// Revision    : 1.0 - initial release
// ============================================================================
module qbert_cube2xy
    import qbert_pkg::*;
#(
    parameter int CUBE_DX = 32,
    parameter int CUBE_DY = 48
) (
    input  logic [ROW_W-1:0] i_row,
    input  logic [COL_W-1:0] i_col,
    input  logic [20:0]      i_xy_offset,
    output logic [X_W-1:0]   o_x,
    output logic [Y_W-1:0]   o_y
);

    logic [X_W-1:0] w_units;

    // Evaluating directly at output width gives the same result as a wider
    // signed evaluation followed by truncation (modular arithmetic).
    assign w_units = {7'd0, i_col, 1'b0} - {8'd0, i_row};
    assign o_x     = i_xy_offset[20:10] + 11'(CUBE_DX) * w_units;
    assign o_y     = i_xy_offset[9:0] + 10'(CUBE_DY) * {7'd0, i_row};

endmodule
`default_nettype wire

// File: rtl/qbert_jump.sv
`default_nettype none
// ============================================================================
// Module      : qbert_jump
// Description : Q*bert jump animator. Holds the current cube and turns a jump
//               request into a per-frame trajectory (linear x, triangular arc
//               in y). A valid landing snaps to the target cube; a jump off the
//               pyramid turns into a fall until the bottom of the screen.
// Ports       : clk, reset (async, active low)
//               frame_tick   one pulse per video frame
//               jump, dir    jump request/direction (accepted in IDLE only)
//               respawn      leave DEAD back to cube (0,0)
//               xy_offset    {ox, oy} pyramid origin
//               position_qb  {x[10:0], y[9:0], row[2:0], col[2:0], on_pyr}
//               done_move_qb 1 = at rest, position final
//               fell         1 while DEAD
// Revision    : 1.0 - initial release
// ============================================================================
module qbert_jump
    import qbert_pkg::*;
#(
    parameter int JUMP_FRAMES = 16,
    parameter int CUBE_DX     = 32,
    parameter int CUBE_DY     = 48,
    parameter int ARC_STEP    = 2,
    parameter int FALL_STEP   = 4,
    parameter int SCREEN_H    = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              jump,
    input  logic [1:0]        dir,
    input  logic              respawn,
    input  logic [20:0]       xy_offset,
    output logic [POS_W-1:0]  position_qb,
    output logic              done_move_qb,
    output logic              fell
);

    localparam int c_fw     = $clog2(JUMP_FRAMES + 1);
    localparam int c_step_x = CUBE_DX / JUMP_FRAMES;
    localparam int c_step_y = CUBE_DY / JUMP_FRAMES;

    jump_state_t      r_state, w_state_nxt;
    logic [X_W-1:0]   r_x, w_x_nxt, r_x0, w_x0_nxt;
    logic [Y_W-1:0]   r_y, w_y_nxt, r_y0, w_y0_nxt;
    logic [ROW_W-1:0] r_row, w_row_nxt;
    logic [COL_W-1:0] r_col, w_col_nxt;
    logic             r_on_pyr, w_on_pyr_nxt;
    logic [c_fw-1:0]  r_f, w_f_nxt;
    dir_t             r_dir, w_dir_nxt;
    cube_t            r_tgt, w_tgt_nxt;
    logic             r_done, w_done_nxt;
    logic             r_fell, w_fell_nxt;

    logic [X_W-1:0]   w_cur_x, w_tgt_x, w_dx, w_jx;
    logic [Y_W-1:0]   w_cur_y, w_tgt_y, w_dy, w_lift, w_jy;
    logic [c_fw-1:0]  w_f_inc, w_f_rem, w_f_arc;
    logic             w_left, w_down;
    logic signed [11:0] w_fall_y;

    qbert_cube2xy #(.CUBE_DX(CUBE_DX), .CUBE_DY(CUBE_DY)) u_cur_xy (
        .i_row       (r_row),
        .i_col       (r_col),
        .i_xy_offset (xy_offset),
        .o_x         (w_cur_x),
        .o_y         (w_cur_y)
    );

    qbert_cube2xy #(.CUBE_DX(CUBE_DX), .CUBE_DY(CUBE_DY)) u_tgt_xy (
        .i_row       (r_tgt.row),
        .i_col       (r_tgt.col),
        .i_xy_offset (xy_offset),
        .o_x         (w_tgt_x),
        .o_y         (w_tgt_y)
    );

    // Trajectory for the frame counter value after this tick.
    assign w_f_inc = r_f + c_fw'(1);
    assign w_f_rem = c_fw'(JUMP_FRAMES) - w_f_inc;
    assign w_f_arc = (w_f_inc < w_f_rem) ? w_f_inc : w_f_rem;
    assign w_left  = (r_dir == UP_LEFT) || (r_dir == DOWN_LEFT);
    assign w_down  = (r_dir == DOWN_RIGHT) || (r_dir == DOWN_LEFT);
    assign w_dx    = 11'(c_step_x) * 11'(w_f_inc);
    assign w_dy    = 10'(c_step_y) * 10'(w_f_inc);
    assign w_lift  = 10'(ARC_STEP) * 10'(w_f_arc);
    assign w_jx    = w_left ? (r_x0 - w_dx) : (r_x0 + w_dx);
    assign w_jy    = (w_down ? (r_y0 + w_dy) : (r_y0 - w_dy)) - w_lift;

    // y is treated as signed while falling so a jump off the top row
    // (y just above the screen) still falls visibly down to SCREEN_H.
    assign w_fall_y = $signed({{2{r_y[9]}}, r_y}) + $signed(12'(FALL_STEP));

    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_x0_nxt     = r_x0;
        w_y0_nxt     = r_y0;
        w_row_nxt    = r_row;
        w_col_nxt    = r_col;
        w_on_pyr_nxt = r_on_pyr;
        w_f_nxt      = r_f;
        w_dir_nxt    = r_dir;
        w_tgt_nxt    = r_tgt;

        case (r_state)
            IDLE: begin
                w_x_nxt = w_cur_x;
                w_y_nxt = w_cur_y;
                if (jump) begin
                    w_dir_nxt   = dir_t'(dir);
                    w_x0_nxt    = w_cur_x;
                    w_y0_nxt    = w_cur_y;
                    w_tgt_nxt   = next_cube(r_row, r_col, dir_t'(dir));
                    w_f_nxt     = '0;
                    w_state_nxt = JUMP;
                end
            end
            JUMP: begin
                if (frame_tick) begin
                    w_f_nxt = w_f_inc;
                    w_x_nxt = w_jx;
                    w_y_nxt = w_jy;
                    if (w_f_inc == c_fw'(JUMP_FRAMES)) begin
                        if (r_tgt.valid) begin
                            w_row_nxt   = r_tgt.row;
                            w_col_nxt   = r_tgt.col;
                            w_x_nxt     = w_tgt_x;
                            w_y_nxt     = w_tgt_y;
                            w_state_nxt = IDLE;
                        end else begin
                            w_on_pyr_nxt = 1'b0;
                            w_state_nxt  = FALL;
                        end
                    end
                end
            end
            FALL: begin
                if (frame_tick) begin
                    if (w_fall_y >= $signed(12'(SCREEN_H))) begin
                        w_y_nxt     = 10'(SCREEN_H);
                        w_state_nxt = DEAD;
                    end else begin
                        w_y_nxt = w_fall_y[9:0];
                    end
                end
            end
            default: begin
                if (respawn) begin
                    w_row_nxt    = '0;
                    w_col_nxt    = '0;
                    w_on_pyr_nxt = 1'b1;
                    w_x_nxt      = xy_offset[20:10];
                    w_y_nxt      = xy_offset[9:0];
                    w_state_nxt  = IDLE;
                end
            end
        endcase

        // Outputs are registered from the next state so done rises on the
        // same edge that loads the final position.
        w_done_nxt = (w_state_nxt == IDLE) || (w_state_nxt == DEAD);
        w_fell_nxt = (w_state_nxt == DEAD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_x0     <= '0;
            r_y0     <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_on_pyr <= 1'b1;
            r_f      <= '0;
            r_dir    <= UP_RIGHT;
            r_tgt    <= '0;
            r_done   <= 1'b1;
            r_fell   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_x0     <= w_x0_nxt;
            r_y0     <= w_y0_nxt;
            r_row    <= w_row_nxt;
            r_col    <= w_col_nxt;
            r_on_pyr <= w_on_pyr_nxt;
            r_f      <= w_f_nxt;
            r_dir    <= w_dir_nxt;
            r_tgt    <= w_tgt_nxt;
            r_done   <= w_done_nxt;
            r_fell   <= w_fell_nxt;
        end
    end

    assign position_qb  = {r_x, r_y, r_row, r_col, r_on_pyr};
    assign done_move_qb = r_done;
    assign fell         = r_fell;

endmodule
`default_nettype wire

// File: tb/tb_qbert_jump.sv
`default_nettype none
// ============================================================================
// Module      : tb_qbert_jump
// Description : Scoreboard bench for qbert_jump. Stimulus pushes hand-computed
//               expectations (immediate, or tied to a frame_tick index); a
//               monitor compares them when the DUT presents the output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qbert_jump;

    localparam int K_NOW  = 0;
    localparam int K_TICK = 1;

    typedef struct {
        int         kind;
        int         tick;
        logic [10:0] x;
        logic [9:0]  y;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        on_pyr;
        logic        done;
        logic        fell;
        int          rises;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        jump = 1'b0;
    logic [1:0]  dir = 2'b00;
    logic        respawn = 1'b0;
    logic [20:0] xy_offset = {11'd320, 10'd40};
    logic [27:0] position_qb;
    logic        done_move_qb;
    logic        fell;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   stim_ticks = 0;
    int   mon_ticks = 0;
    int   rises = 0;
    logic tick_seen = 1'b0;
    logic prev_done = 1'b1;

    qbert_jump dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .jump         (jump),
        .dir          (dir),
        .respawn      (respawn),
        .xy_offset    (xy_offset),
        .position_qb  (position_qb),
        .done_move_qb (done_move_qb),
        .fell         (fell)
    );

    always #5 clk = ~clk;

    function automatic void push(string name, int kind, int tick, int x, int y,
                                 int row, int col, bit on_pyr, bit done,
                                 bit fl, int r);
        exp_t e;
        e.name   = name;
        e.kind   = kind;
        e.tick   = tick;
        e.x      = 11'(x);
        e.y      = 10'(y);
        e.row    = 3'(row);
        e.col    = 3'(col);
        e.on_pyr = on_pyr;
        e.done   = done;
        e.fell   = fl;
        e.rises  = r;
        sb.push_back(e);
    endfunction

    task automatic compare(input exp_t e);
        logic [27:0] want;
        want = {e.x, e.y, e.row, e.col, e.on_pyr};
        checks++;
        if (position_qb !== want || done_move_qb !== e.done || fell !== e.fell ||
            rises != e.rises) begin
            failures++;
            $display("FAIL %s: got x=%0d y=%0d row=%0d col=%0d on_pyr=%b done=%b fell=%b rises=%0d, want x=%0d y=%0d row=%0d col=%0d on_pyr=%b done=%b fell=%b rises=%0d",
                     e.name, position_qb[27:17], position_qb[16:7], position_qb[6:4],
                     position_qb[3:1], position_qb[0], done_move_qb, fell, rises,
                     e.x, e.y, e.row, e.col, e.on_pyr, e.done, e.fell, e.rises);
        end
    endtask

    // Tick tracker: which edge just consumed a frame_tick.
    initial forever begin
        @(posedge clk);
        tick_seen = frame_tick;
        if (frame_tick) mon_ticks++;
    end

    // Monitor: counts done rising edges and retires scoreboard entries.
    initial forever begin
        @(negedge clk);
        if (done_move_qb === 1'b1 && prev_done === 1'b0) rises++;
        prev_done = done_move_qb;
        if (sb.size() != 0) begin
            if (sb[0].kind == K_NOW || (tick_seen && mon_ticks == sb[0].tick)) begin
                compare(sb[0]);
                void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        frame_tick = 1'b1;
        stim_ticks++;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_jump(input logic [1:0] d);
        jump = 1'b1;
        dir  = d;
        @(posedge clk); #1;
        jump = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        while (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout %s: still pending after %0d cycles, want it observed",
                     sb[0].name, max_cycles);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int b;
        // Reset values while held in reset.
        push("reset_hold", K_NOW, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        drain(10);
        reset = 1'b1;
        @(posedge clk); #1;
        push("reset_load", K_NOW, 0, 320, 40, 0, 0, 1, 1, 0, 0);
        drain(10);

        // Down-right from (0,0) to (1,1).
        pulse_jump(2'b10);
        push("dr_accept", K_NOW, 0, 320, 40, 0, 0, 1, 0, 0, 0);
        drain(10);
        b = stim_ticks;
        push("dr_t1",  K_TICK, b + 1,  322, 41, 0, 0, 1, 0, 0, 0);
        push("dr_t8",  K_TICK, b + 8,  336, 48, 0, 0, 1, 0, 0, 0);
        push("dr_t15", K_TICK, b + 15, 350, 83, 0, 0, 1, 0, 0, 0);
        push("dr_t16", K_TICK, b + 16, 352, 88, 1, 1, 1, 1, 0, 1);
        ticks(16);
        drain(20);

        // Up-left from (1,1) back to (0,0); a second jump mid-flight is ignored.
        pulse_jump(2'b01);
        b = stim_ticks;
        push("ul_t4",  K_TICK, b + 4,  344, 68, 1, 1, 1, 0, 0, 1);
        push("ul_t8",  K_TICK, b + 8,  336, 48, 1, 1, 1, 0, 0, 1);
        push("ul_t16", K_TICK, b + 16, 320, 40, 0, 0, 1, 1, 0, 2);
        ticks(4);
        pulse_jump(2'b10);
        ticks(12);
        drain(20);

        // Up-right off the apex: fall to the bottom of the screen.
        pulse_jump(2'b00);
        b = stim_ticks;
        push("ur_t16", K_TICK, b + 16, 352, 1016, 0, 0, 0, 0, 0, 2);
        ticks(16);
        drain(20);
        b = stim_ticks;
        push("fall_1",   K_TICK, b + 1,   352, 1020, 0, 0, 0, 0, 0, 2);
        push("fall_121", K_TICK, b + 121, 352, 476,  0, 0, 0, 0, 0, 2);
        push("fall_122", K_TICK, b + 122, 352, 480,  0, 0, 0, 1, 1, 3);
        push("dead_tick", K_TICK, b + 123, 352, 480, 0, 0, 0, 1, 1, 3);
        ticks(123);
        drain(20);
        pulse_jump(2'b10);
        push("dead_jump", K_NOW, 0, 352, 480, 0, 0, 0, 1, 1, 3);
        drain(10);
        respawn = 1'b1;
        @(posedge clk); #1;
        respawn = 1'b0;
        push("respawn", K_NOW, 0, 320, 40, 0, 0, 1, 1, 0, 3);
        drain(10);

        // Reset in the middle of a jump.
        pulse_jump(2'b10);
        b = stim_ticks;
        push("rst_t5", K_TICK, b + 5, 330, 45, 0, 0, 1, 0, 0, 3);
        ticks(5);
        drain(20);
        reset = 1'b0;
        push("rst_mid", K_NOW, 0, 0, 0, 0, 0, 1, 1, 0, 4);
        @(posedge clk); #1;
        drain(10);
        reset = 1'b1;
        @(posedge clk); #1;
        push("rst_reload", K_NOW, 0, 320, 40, 0, 0, 1, 1, 0, 4);
        drain(10);

        // Down-left from (0,0) to (1,0).
        pulse_jump(2'b11);
        b = stim_ticks;
        push("dl_t8",  K_TICK, b + 8,  304, 48, 0, 0, 1, 0, 0, 4);
        push("dl_t16", K_TICK, b + 16, 288, 88, 1, 0, 1, 1, 0, 5);
        ticks(16);
        drain(20);

        // Jump and frame_tick together: the tick does not advance the jump.
        jump = 1'b1;
        dir = 2'b10;
        frame_tick = 1'b1;
        stim_ticks++;
        b = stim_ticks;
        push("co_t0", K_TICK, b, 288, 88, 1, 0, 1, 0, 0, 5);
        @(posedge clk); #1;
        jump = 1'b0;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        push("co_t15", K_TICK, b + 15, 318, 131, 1, 0, 1, 0, 0, 5);
        push("co_t16", K_TICK, b + 16, 320, 136, 2, 1, 1, 1, 0, 6);
        ticks(16);
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
